button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end conditioning stage for the four DE1-SoC push buttons (KEY[3:0], raw, active-low, bouncing, asynchronous to the system clock). Each button is synchronised and debounced, and gets a press strobe with auto-repeat. The block also generates the slow `buttonClockOut` square wave. Its debounced active-low levels and `buttonClockOut` drive the `butt0..butt3` and `buttonClock` inputs of the cursor/wave control block directly downstream. The press strobes serve logic that needs one event per press.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a synchronised level must differ from the stable level before the stable level flips (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000: cycles from the initial press strobe to the first repeat strobe (500 ms).
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat strobes (100 ms).
- CLK_DIV, 250000: half-period of `buttonClockOut`, in clock cycles (100 Hz).
- All parameters must satisfy 1 ≤ value < 2^25. All counters are 25 bits wide and unsigned, and always return to 0, never wrap.

Ports:
- clock  in  1  system clock, 50 MHz (CLOCK_50).
- reset_n  in  1  asynchronous, active-low reset.
- key_n  in  4  raw buttons, active-low, asynchronous to `clock`.
- butt_n  out  4  debounced stable levels, active-low; bit i feeds `butt<i>`.
- press  out  4  one-cycle strobe per initial press and per auto-repeat, active-high.
- any_press  out  1  OR of `press`, same cycle.
- buttonClockOut  out  1  square wave with period 2*CLK_DIV cycles.
- tick  out  1  one-cycle strobe in the cycle `buttonClockOut` rises.

## Operation
- Synchroniser: 2-flop chain per bit produces `sync[i]`. Both flops reset to 1.
- Debounce, per bit:
  - `stable[i]` resets to 1 and drives `butt_n[i]`.
  - While `sync != stable`, `dcnt` increments every cycle.
  - Whenever `sync == stable`, `dcnt` clears to 0, so a single-cycle glitch restarts the count.
  - When `dcnt == DEBOUNCE_CYCLES-1` and the levels still differ: `stable <= sync` and `dcnt <= 0`.
- Repeat FSM, per bit, independent of the other bits. States are RELEASED, HOLD_WAIT and HOLD_REPEAT.
  - RELEASED: on the cycle `stable` falls 1→0, assert `press[i]`, clear `rcnt`, go to HOLD_WAIT.
  - HOLD_WAIT: `rcnt` increments. At `rcnt == REPEAT_DELAY-1`, assert `press[i]`, clear `rcnt`, go to HOLD_REPEAT.
  - HOLD_REPEAT: `rcnt` increments. At `rcnt == REPEAT_PERIOD-1`, assert `press[i]` and clear `rcnt`.
  - From either hold state, the cycle `stable` rises to 1: go to RELEASED, clear `rcnt`, no strobe. The release check has priority over a repeat strobe in the same cycle.
- Divider:
  - `divcnt` counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it clears and `buttonClockOut` toggles.
  - `tick` is asserted in the cycle the register becomes 1.
  - The divider free-runs and is not affected by buttons.
- Simultaneous presses on several bits each produce their own strobe in the same cycle. `any_press` is a single-cycle pulse in that cycle.

## Timing
- Reset values:
  - `butt_n` = 4'hF, `press` = 0, `any_press` = 0, `buttonClockOut` = 0, `tick` = 0.
  - All FSMs in RELEASED, all counters 0.
- All outputs are registered; none are combinational from `key_n`.
- Press latency: `key_n[i]` low and stable, first sampled at edge t. `butt_n[i]` falls and `press[i]` pulses at edge t+1+DEBOUNCE_CYCLES, for both outputs in the same cycle.
- Release latency is identical for `butt_n`.
- Repeat strobes come REPEAT_DELAY cycles after the initial strobe, then every REPEAT_PERIOD cycles while `butt_n[i]` stays low.
- Reset asserted mid-hold clears everything immediately. After deassertion, a button still held must re-debounce and produces exactly one fresh initial strobe.
- Bounce shorter than DEBOUNCE_CYCLES never changes `butt_n` and never produces a strobe.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, CLK_DIV=2.
1. Reset with all keys released. Expect `butt_n`=F, `press`=0. `buttonClockOut` toggles every 2 cycles with period 4, and `tick` pulses once per 4 cycles.
2. `key_n[0]` low, first sampled at edge 0, held. Expect `butt_n[0]` to fall and `press[0]` to pulse at edge 5. Repeat strobes at edges 15, 18, 21, ...
3. `key_n[1]` bouncing: low 3 cycles, high 1, low 3, high. Expect `butt_n[1]` to stay 1 and `press` to stay 0 throughout.
4. `key_n[2]` and `key_n[3]` low in the same cycle. Expect `press` = 4'hC in one cycle and `any_press` to pulse once.
5. Hold `key_n[0]` past the first repeat, then release. Expect `butt_n[0]` to return to 1 five cycles after release, with no further strobes, including when release lands on a repeat cycle.
6. Pulse `reset_n` low mid-hold with `key_n[0]` still low. Expect outputs at reset values; after deassertion, a single new `press[0]` five cycles later.

Source files
------------

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner_if
// Purpose  : Bundles the raw key inputs and the conditioned button outputs
//            of button_conditioner. The slave side is the conditioner and the
//            master side is whatever drives the keys and consumes the results.
// Revision : 1.0 - initial release
// ============================================================================
interface button_conditioner_if;
  logic [3:0] key_n;           // raw buttons, active-low, asynchronous
  logic [3:0] butt_n;          // debounced stable levels, active-low
  logic [3:0] press;           // initial-press and auto-repeat strobes
  logic       any_press;       // OR of press
  logic       buttonClockOut;  // slow square wave
  logic       tick;            // strobe on the rising edge of buttonClockOut

  modport master (
    output key_n,
    input  butt_n, press, any_press, buttonClockOut, tick
  );

  modport slave (
    input  key_n,
    output butt_n, press, any_press, buttonClockOut, tick
  );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronises and debounces four raw active-low push buttons,
//            produces a press strobe with auto-repeat per button, and
//            generates a free-running slow square wave with a rise strobe.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned CLK_DIV         = 250000
) (
  input  wire logic              clock,
  input  wire logic              reset_n,
  button_conditioner_if.slave    io_bus
);

  // Terminal counts; every counter is 25 bits and clears on reaching these.
  localparam logic [24:0] c_DEB_LAST = 25'(DEBOUNCE_CYCLES - 1);
  localparam logic [24:0] c_RD_LAST  = 25'(REPEAT_DELAY - 1);
  localparam logic [24:0] c_RP_LAST  = 25'(REPEAT_PERIOD - 1);
  localparam logic [24:0] c_DIV_LAST = 25'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HOLD_WAIT   = 2'd1,
    HOLD_REPEAT = 2'd2
  } state_t;

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  w_press_nxt;
  logic        r_any_press;
  logic [24:0] r_divcnt;
  logic        r_bclk;
  logic        r_tick;

  // Two-flop synchroniser; resets to the released level so no false press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= io_bus.key_n;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      logic        r_stable;
      logic [24:0] r_dcnt;
      logic        w_flip;
      logic        w_fall;
      logic        w_rise;
      state_t      r_state;
      state_t      w_state_nxt;
      logic [24:0] r_rcnt;
      logic [24:0] w_rcnt_nxt;
      logic        w_strobe;
      logic        r_press;

      // The stable level flips on this edge; fall/rise tell the FSM which
      // way, so the strobe lands in the same cycle as the new butt_n.
      assign w_flip = (r_sync2[gi] != r_stable) && (r_dcnt == c_DEB_LAST);
      assign w_fall = w_flip &&  r_stable;
      assign w_rise = w_flip && !r_stable;

      // Debounce: count cycles of disagreement, restart on any agreement.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_stable <= 1'b1;
          r_dcnt   <= 25'd0;
        end else if (r_sync2[gi] == r_stable) begin
          r_dcnt   <= 25'd0;
        end else if (r_dcnt == c_DEB_LAST) begin
          r_stable <= r_sync2[gi];
          r_dcnt   <= 25'd0;
        end else begin
          r_dcnt   <= r_dcnt + 25'd1;
        end
      end

      // Repeat FSM state, repeat counter and registered strobe.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_state <= RELEASED;
          r_rcnt  <= 25'd0;
          r_press <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_rcnt  <= w_rcnt_nxt;
          r_press <= w_strobe;
        end
      end

      // Repeat FSM next state; a release always beats a due repeat strobe.
      always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_strobe    = 1'b0;
        case (r_state)
          RELEASED: begin
            if (w_fall) begin
              w_strobe    = 1'b1;
              w_rcnt_nxt  = 25'd0;
              w_state_nxt = HOLD_WAIT;
            end
          end
          HOLD_WAIT: begin
            if (w_rise) begin
              w_rcnt_nxt  = 25'd0;
              w_state_nxt = RELEASED;
            end else if (r_rcnt == c_RD_LAST) begin
              w_strobe    = 1'b1;
              w_rcnt_nxt  = 25'd0;
              w_state_nxt = HOLD_REPEAT;
            end else begin
              w_rcnt_nxt  = r_rcnt + 25'd1;
            end
          end
          HOLD_REPEAT: begin
            if (w_rise) begin
              w_rcnt_nxt  = 25'd0;
              w_state_nxt = RELEASED;
            end else if (r_rcnt == c_RP_LAST) begin
              w_strobe    = 1'b1;
              w_rcnt_nxt  = 25'd0;
            end else begin
              w_rcnt_nxt  = r_rcnt + 25'd1;
            end
          end
          default: begin
            w_rcnt_nxt  = 25'd0;
            w_state_nxt = RELEASED;
          end
        endcase
      end

      assign w_press_nxt[gi]   = w_strobe;
      assign io_bus.butt_n[gi] = r_stable;
      assign io_bus.press[gi]  = r_press;
    end
  endgenerate

  // any_press is registered from the same next-strobe vector as press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_any_press <= 1'b0;
    end else begin
      r_any_press <= |w_press_nxt;
    end
  end

  // Free-running divider: toggle every CLK_DIV cycles, strobe on the rise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_divcnt <= 25'd0;
      r_bclk   <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= (r_divcnt == c_DIV_LAST) && !r_bclk;
      if (r_divcnt == c_DIV_LAST) begin
        r_divcnt <= 25'd0;
        r_bclk   <= ~r_bclk;
      end else begin
        r_divcnt <= r_divcnt + 25'd1;
      end
    end
  end

  assign io_bus.any_press      = r_any_press;
  assign io_bus.buttonClockOut = r_bclk;
  assign io_bus.tick           = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Directed plus randomized bench for button_conditioner, checked
//            every cycle against a sample-window / arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int DIV = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  button_conditioner_if io_bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CLK_DIV        (DIV)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .io_bus (io_bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: key samples since reset, model stable level, fall edge.
  logic [3:0] q_hist[$];
  logic [3:0] m_stable;
  logic [3:0] m_press;
  logic       m_bclk;
  logic       m_tick;
  int         m_t0[4];
  int         n_edge;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_hist.delete();
    repeat (DEB + 2) q_hist.push_back(4'hF);
    m_stable = 4'hF;
    m_press  = 4'h0;
    m_bclk   = 1'b0;
    m_tick   = 1'b0;
    n_edge   = 0;
    for (int i = 0; i < 4; i++) m_t0[i] = 0;
  endtask

  // Stable flips once DEB consecutive samples, ending two edges back, all
  // disagree with it. Strobes follow from the time since the fall.
  task automatic model_edge(input logic [3:0] k);
    int  last;
    int  d;
    logic all_diff;
    n_edge++;
    q_hist.push_back(k);
    if (q_hist.size() > DEB + 3) void'(q_hist.pop_front());
    last = q_hist.size() - 1;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      for (int j = last - 1 - DEB; j <= last - 2; j++) begin
        if (q_hist[j][i] == m_stable[i]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_stable[i] = ~m_stable[i];
        if (m_stable[i] == 1'b0) m_t0[i] = n_edge;
      end
      d = n_edge - m_t0[i];
      m_press[i] = !m_stable[i] && ((d == 0) || (d >= RD && ((d - RD) % RP) == 0));
    end
    m_bclk = ((n_edge / DIV) % 2) == 1;
    m_tick = ((n_edge % DIV) == 0) && m_bclk;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge(io_bus.key_n);
    #1;
    check("butt_n",         32'(io_bus.butt_n),         32'(m_stable));
    check("press",          32'(io_bus.press),          32'(m_press));
    check("any_press",      32'(io_bus.any_press),      32'(|m_press));
    check("buttonClockOut", 32'(io_bus.buttonClockOut), 32'(m_bclk));
    check("tick",           32'(io_bus.tick),           32'(m_tick));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_butt_n"}, 32'(io_bus.butt_n),         32'hF);
    check({tag, "_press"},  32'(io_bus.press),          32'h0);
    check({tag, "_any"},    32'(io_bus.any_press),      32'h0);
    check({tag, "_bclk"},   32'(io_bus.buttonClockOut), 32'h0);
    check({tag, "_tick"},   32'(io_bus.tick),           32'h0);
  endtask

  initial begin
    int cnt;
    int cnt_any;
    int dur[4];

    io_bus.key_n = 4'hF;
    reset_n      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("reset");
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();

    // 1: idle, divider only
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (io_bus.tick) cnt++;
    end
    check("t1_tick_count", 32'(cnt), 32'd2);

    // 2: key0 held, initial strobe and repeats
    io_bus.key_n[0] = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      step();
      if (k == 4)  check("t2_butt0_before", 32'(io_bus.butt_n[0]), 32'd1);
      if (k == 5)  check("t2_press_edge5",  32'(io_bus.press[0]),  32'd1);
      if (k == 15) check("t2_press_edge15", 32'(io_bus.press[0]),  32'd1);
      if (k == 18) check("t2_press_edge18", 32'(io_bus.press[0]),  32'd1);
      if (k == 21) check("t2_press_edge21", 32'(io_bus.press[0]),  32'd1);
    end
    io_bus.key_n[0] = 1'b1;
    repeat (12) step();

    // 3: bounce on key1, never long enough to register
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      io_bus.key_n[1] = (k < 3 || (k >= 4 && k < 7)) ? 1'b0 : 1'b1;
      step();
      if (io_bus.butt_n[1] !== 1'b1 || io_bus.press !== 4'h0) cnt++;
    end
    check("t3_bounce_events", 32'(cnt), 32'd0);

    // 4: keys 2 and 3 together
    io_bus.key_n[3:2] = 2'b00;
    cnt     = 0;
    cnt_any = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (io_bus.press == 4'hC) cnt++;
      if (io_bus.any_press) cnt_any++;
    end
    check("t4_pressC_cycles", 32'(cnt),     32'd1);
    check("t4_any_pulses",    32'(cnt_any), 32'd1);
    io_bus.key_n[3:2] = 2'b11;
    repeat (10) step();

    // 5: release timed so the rise lands on a repeat cycle
    io_bus.key_n[0] = 1'b0;
    repeat (16) step();
    io_bus.key_n[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 5) check("t5_butt0_held", 32'(io_bus.butt_n[0]), 32'd0);
      if (k == 6) begin
        check("t5_butt0_released", 32'(io_bus.butt_n[0]), 32'd1);
        check("t5_no_repeat",      32'(io_bus.press[0]),  32'd0);
      end
    end

    // 6: reset mid-hold, then exactly one fresh strobe
    io_bus.key_n[0] = 1'b0;
    repeat (20) step();
    reset_n = 1'b0;
    #1;
    check_reset_vals("t6_async");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (io_bus.press[0]) cnt++;
      if (k == 6) check("t6_press_edge6", 32'(io_bus.press[0]), 32'd1);
    end
    check("t6_press_count", 32'(cnt), 32'd1);
    io_bus.key_n[0] = 1'b1;
    repeat (10) step();

    // Randomized: per-key runs mixing short bounces and long holds
    for (int i = 0; i < 4; i++) dur[i] = $urandom_range(1, 20);
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (dur[i] == 0) begin
          io_bus.key_n[i] = ~io_bus.key_n[i];
          dur[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(15, 45) : $urandom_range(1, 6);
        end else begin
          dur[i]--;
        end
      end
      step();
    end
    io_bus.key_n = 4'hF;
    repeat (12) step();
    check("final_released", 32'(io_bus.butt_n), 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
